// File: rtl/gpio_pkg.sv
// Shared register map and access-legality helper for the APB GPIO bank.
package gpio_pkg;

  localparam int unsigned ADDR_W = 5;

  localparam logic [ADDR_W-1:0] ADDR_DIR     = 5'h00;
  localparam logic [ADDR_W-1:0] ADDR_OUT     = 5'h01;
  localparam logic [ADDR_W-1:0] ADDR_IN      = 5'h02;
  localparam logic [ADDR_W-1:0] ADDR_SET     = 5'h03;
  localparam logic [ADDR_W-1:0] ADDR_CLR     = 5'h04;
  localparam logic [ADDR_W-1:0] ADDR_IE      = 5'h05;
  localparam logic [ADDR_W-1:0] ADDR_RISE_EN = 5'h06;
  localparam logic [ADDR_W-1:0] ADDR_FALL_EN = 5'h07;
  localparam logic [ADDR_W-1:0] ADDR_IS      = 5'h08;
  localparam logic [ADDR_W-1:0] ADDR_MAX     = ADDR_IS;

  // Unmapped addresses and writes to the read-only IN register are errors.
  function automatic logic addr_is_err(input logic [ADDR_W-1:0] addr, input logic write);
    return (addr > ADDR_MAX) || (write && (addr == ADDR_IN));
  endfunction

endpackage

// File: rtl/apb_gpio_bank_if.sv
// APB slave bus bundle for the GPIO bank.
interface apb_gpio_bank_if
  import gpio_pkg::*;
#(
  parameter int unsigned WIDTH = 16
);
  logic              PSEL;
  logic              PENABLE;
  logic              PWRITE;
  logic [ADDR_W-1:0] PADDR;
  logic [WIDTH-1:0]  PWDATA;
  logic [WIDTH-1:0]  PRDATA;
  logic              PREADY;
  logic              PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/gpio_sync_edge.sv
// Vector input synchroniser with one history stage for rise/fall detection.
module gpio_sync_edge #(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             PCLK,
  input  logic             PRESETn,
  input  logic [WIDTH-1:0] i_async_in,
  output logic [WIDTH-1:0] o_sync_out,
  output logic [WIDTH-1:0] o_rise,
  output logic [WIDTH-1:0] o_fall
);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] r_sync;
  logic [WIDTH-1:0]                  r_prev;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_sync <= '0;
      r_prev <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_async_in};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_sync_out = r_sync[SYNC_STAGES-1];
  assign o_rise     = r_sync[SYNC_STAGES-1] & ~r_prev;
  assign o_fall     = ~r_sync[SYNC_STAGES-1] & r_prev;

endmodule

// File: rtl/apb_gpio_bank.sv
// APB GPIO bank: direction/output registers, edge-capture status and registered irq.
module apb_gpio_bank
  import gpio_pkg::*;
#(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             PCLK,
  input  logic             PRESETn,
  apb_gpio_bank_if.slave   apb,
  input  logic [WIDTH-1:0] i_gpio_in,
  output logic [WIDTH-1:0] o_gpio_out,
  output logic [WIDTH-1:0] o_gpio_oe,
  output logic             o_irq
);

  logic [WIDTH-1:0] r_dir, r_out, r_ie, r_rise_en, r_fall_en, r_is;
  logic             r_irq;
  logic [WIDTH-1:0] w_dir_d, w_out_d, w_ie_d, w_rise_en_d, w_fall_en_d, w_is_d;
  logic [WIDTH-1:0] w_sync, w_rise, w_fall, w_event, w_w1c, w_rdata;
  logic             w_access, w_err, w_wr, w_rd;

  gpio_sync_edge #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync_edge (
    .PCLK       (PCLK),
    .PRESETn    (PRESETn),
    .i_async_in (i_gpio_in),
    .o_sync_out (w_sync),
    .o_rise     (w_rise),
    .o_fall     (w_fall)
  );

  assign w_access = apb.PSEL & apb.PENABLE;
  assign w_err    = w_access & addr_is_err(apb.PADDR, apb.PWRITE);
  assign w_wr     = w_access & apb.PWRITE & ~w_err;
  assign w_rd     = w_access & ~apb.PWRITE & ~w_err;

  always_comb begin
    w_dir_d     = r_dir;
    w_out_d     = r_out;
    w_ie_d      = r_ie;
    w_rise_en_d = r_rise_en;
    w_fall_en_d = r_fall_en;
    w_w1c       = '0;
    if (w_wr) begin
      case (apb.PADDR)
        ADDR_DIR:     w_dir_d     = apb.PWDATA;
        ADDR_OUT:     w_out_d     = apb.PWDATA;
        ADDR_SET:     w_out_d     = r_out | apb.PWDATA;
        ADDR_CLR:     w_out_d     = r_out & ~apb.PWDATA;
        ADDR_IE:      w_ie_d      = apb.PWDATA;
        ADDR_RISE_EN: w_rise_en_d = apb.PWDATA;
        ADDR_FALL_EN: w_fall_en_d = apb.PWDATA;
        ADDR_IS:      w_w1c       = apb.PWDATA;
        default:      ;
      endcase
    end
    // A fresh edge outranks a simultaneous W1C on the same bit.
    w_event = (w_rise & r_rise_en) | (w_fall & r_fall_en);
    w_is_d  = (r_is & ~w_w1c) | w_event;
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_dir     <= '0;
      r_out     <= '0;
      r_ie      <= '0;
      r_rise_en <= '0;
      r_fall_en <= '0;
      r_is      <= '0;
      r_irq     <= 1'b0;
    end else begin
      r_dir     <= w_dir_d;
      r_out     <= w_out_d;
      r_ie      <= w_ie_d;
      r_rise_en <= w_rise_en_d;
      r_fall_en <= w_fall_en_d;
      r_is      <= w_is_d;
      r_irq     <= |(r_is & r_ie);
    end
  end

  always_comb begin
    w_rdata = '0;
    if (w_rd) begin
      case (apb.PADDR)
        ADDR_DIR:     w_rdata = r_dir;
        ADDR_OUT:     w_rdata = r_out;
        ADDR_IN:      w_rdata = w_sync;
        ADDR_IE:      w_rdata = r_ie;
        ADDR_RISE_EN: w_rdata = r_rise_en;
        ADDR_FALL_EN: w_rdata = r_fall_en;
        ADDR_IS:      w_rdata = r_is;
        default:      w_rdata = '0;
      endcase
    end
  end

  assign apb.PRDATA  = w_rdata;
  assign apb.PREADY  = 1'b1;
  assign apb.PSLVERR = w_err;

  assign o_gpio_out = r_out;
  assign o_gpio_oe  = r_dir;
  assign o_irq      = r_irq;

endmodule

// File: tb/tb_apb_gpio_bank.sv
// Self-checking bench for apb_gpio_bank: directed scenarios plus randomized traffic vs a model.
module tb_apb_gpio_bank;

  localparam int unsigned W = 16;
  localparam int unsigned S = 2;

  logic         PCLK = 1'b0;
  logic         PRESETn = 1'b0;
  logic [W-1:0] gpio_in, gpio_out, gpio_oe;
  logic         irq;
  int           n_cmp = 0;
  int           n_bad = 0;

  apb_gpio_bank_if #(.WIDTH(W)) bus ();

  apb_gpio_bank #(
    .WIDTH       (W),
    .SYNC_STAGES (S)
  ) dut (
    .PCLK       (PCLK),
    .PRESETn    (PRESETn),
    .apb        (bus.slave),
    .i_gpio_in  (gpio_in),
    .o_gpio_out (gpio_out),
    .o_gpio_oe  (gpio_oe),
    .o_irq      (irq)
  );

  always #5 PCLK = ~PCLK;

  // Reference model: register file plus a history of pin samples (hist[0] = newest).
  logic [W-1:0] m_dir, m_out, m_ie, m_re, m_fe, m_is;
  logic         m_irq;
  logic [W-1:0] hist [S+1];

  always @(posedge PCLK or negedge PRESETn) begin : model
    logic [W-1:0] snc, prv, ev, w1c;
    if (!PRESETn) begin
      m_dir = '0; m_out = '0; m_ie = '0; m_re = '0; m_fe = '0; m_is = '0; m_irq = 1'b0;
      for (int i = 0; i <= S; i++) hist[i] = '0;
    end else begin
      snc   = hist[S-1];
      prv   = hist[S];
      ev    = (snc & ~prv & m_re) | (~snc & prv & m_fe);
      w1c   = '0;
      m_irq = |(m_is & m_ie);
      if (bus.PSEL && bus.PENABLE && bus.PWRITE && bus.PADDR <= 5'd8 && bus.PADDR != 5'd2) begin
        case (bus.PADDR)
          5'd0: m_dir = bus.PWDATA;
          5'd1: m_out = bus.PWDATA;
          5'd3: m_out = m_out | bus.PWDATA;
          5'd4: m_out = m_out & ~bus.PWDATA;
          5'd5: m_ie  = bus.PWDATA;
          5'd6: m_re  = bus.PWDATA;
          5'd7: m_fe  = bus.PWDATA;
          5'd8: w1c   = bus.PWDATA;
          default: ;
        endcase
      end
      m_is = (m_is & ~w1c) | ev;
      for (int i = S; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = gpio_in;
    end
  end

  function automatic logic [W-1:0] exp_reg(input logic [4:0] a);
    case (a)
      5'd0: return m_dir;
      5'd1: return m_out;
      5'd2: return hist[S-1];
      5'd5: return m_ie;
      5'd6: return m_re;
      5'd7: return m_fe;
      5'd8: return m_is;
      default: return '0;
    endcase
  endfunction

  // One APB transfer; returns observed and expected access-phase responses, ends on commit edge.
  task automatic xfer(input logic wr, input logic [4:0] addr, input logic [W-1:0] data,
                      output logic [W-1:0] rd, output logic err,
                      output logic [W-1:0] erd, output logic eerr);
    @(negedge PCLK);
    bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = wr; bus.PADDR = addr; bus.PWDATA = data;
    @(negedge PCLK);
    bus.PENABLE = 1'b1;
    #1;
    rd   = bus.PRDATA;
    err  = bus.PSLVERR;
    eerr = (addr > 5'd8) || (wr && addr == 5'd2);
    erd  = (wr || eerr) ? '0 : exp_reg(addr);
    @(posedge PCLK);
  endtask

  task automatic idle();
    @(negedge PCLK);
    bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    logic [W-1:0] rd, erd;
    logic err, eerr;
    PRESETn = 1'b0;
    repeat (3) @(posedge PCLK);
    @(negedge PCLK);
    PRESETn = 1'b1;
    #1;
    n_cmp++; if (gpio_oe !== '0) begin n_bad++; $display("FAIL reset_oe: got %h want 0", gpio_oe); end
    n_cmp++; if (gpio_out !== '0) begin n_bad++; $display("FAIL reset_out: got %h want 0", gpio_out); end
    n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL reset_irq: got %b want 0", irq); end
    n_cmp++; if (bus.PSLVERR !== 1'b0) begin n_bad++; $display("FAIL reset_slverr: got %b want 0", bus.PSLVERR); end
    for (int a = 0; a <= 8; a++) begin
      xfer(1'b0, 5'(a), '0, rd, err, erd, eerr);
      n_cmp++; if (rd !== '0) begin n_bad++; $display("FAIL reset_read[%0d]: got %h want 0", a, rd); end
      n_cmp++; if (bus.PREADY !== 1'b1) begin n_bad++; $display("FAIL reset_pready[%0d]: got %b want 1", a, bus.PREADY); end
    end
    idle();
  endtask

  task automatic test_dir_out();
    logic [W-1:0] rd, erd;
    logic err, eerr;
    xfer(1'b1, 5'd0, 16'h00FF, rd, err, erd, eerr);
    xfer(1'b1, 5'd1, 16'hA5A5, rd, err, erd, eerr);
    idle();
    n_cmp++; if (gpio_oe !== 16'h00FF) begin n_bad++; $display("FAIL dir_oe: got %h want 00ff", gpio_oe); end
    n_cmp++; if (gpio_out !== 16'hA5A5) begin n_bad++; $display("FAIL out_val: got %h want a5a5", gpio_out); end
    xfer(1'b1, 5'd3, 16'h000A, rd, err, erd, eerr);
    idle();
    n_cmp++; if (gpio_out !== 16'hA5AF) begin n_bad++; $display("FAIL set_out: got %h want a5af", gpio_out); end
    xfer(1'b1, 5'd4, 16'hA000, rd, err, erd, eerr);
    idle();
    n_cmp++; if (gpio_out !== 16'h05AF) begin n_bad++; $display("FAIL clr_out: got %h want 05af", gpio_out); end
    xfer(1'b0, 5'd1, '0, rd, err, erd, eerr);
    n_cmp++; if (rd !== 16'h05AF) begin n_bad++; $display("FAIL out_read: got %h want 05af", rd); end
    xfer(1'b0, 5'd3, '0, rd, err, erd, eerr);
    n_cmp++; if (rd !== '0 || err !== 1'b0) begin n_bad++; $display("FAIL set_read: got %h/%b want 0/0", rd, err); end
    idle();
  endtask

  task automatic test_rise_irq();
    logic [W-1:0] rd, erd;
    logic err, eerr;
    xfer(1'b1, 5'd6, 16'h0001, rd, err, erd, eerr);
    xfer(1'b1, 5'd5, 16'h0001, rd, err, erd, eerr);
    idle();
    gpio_in[0] = 1'b1;
    // Access phase falls after the second edge following the pin change.
    xfer(1'b0, 5'd2, '0, rd, err, erd, eerr);
    n_cmp++; if (rd[0] !== 1'b1) begin n_bad++; $display("FAIL in_latency: got %b want 1", rd[0]); end
    idle();
    n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL irq_cycle3: got %b want 0", irq); end
    @(negedge PCLK); #1;
    n_cmp++; if (irq !== 1'b1) begin n_bad++; $display("FAIL irq_cycle4: got %b want 1", irq); end
    xfer(1'b0, 5'd8, '0, rd, err, erd, eerr);
    n_cmp++; if (rd !== 16'h0001) begin n_bad++; $display("FAIL is_rise: got %h want 0001", rd); end
    xfer(1'b1, 5'd8, 16'h0001, rd, err, erd, eerr);
    idle();
    n_cmp++; if (irq !== 1'b1) begin n_bad++; $display("FAIL irq_hold: got %b want 1", irq); end
    @(negedge PCLK); #1;
    n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL irq_w1c: got %b want 0", irq); end
  endtask

  task automatic test_fall_no_ie();
    logic [W-1:0] rd, erd;
    logic err, eerr;
    xfer(1'b1, 5'd7, 16'h0002, rd, err, erd, eerr);
    xfer(1'b1, 5'd5, 16'h0000, rd, err, erd, eerr);
    idle();
    gpio_in[1] = 1'b1;
    repeat (5) @(negedge PCLK);
    gpio_in[1] = 1'b0;
    repeat (5) @(negedge PCLK);
    xfer(1'b0, 5'd8, '0, rd, err, erd, eerr);
    n_cmp++; if (rd !== 16'h0002) begin n_bad++; $display("FAIL is_fall: got %h want 0002", rd); end
    idle();
    n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL irq_masked: got %b want 0", irq); end
    xfer(1'b1, 5'd5, 16'h0002, rd, err, erd, eerr);
    idle();
    @(negedge PCLK); #1;
    n_cmp++; if (irq !== 1'b1) begin n_bad++; $display("FAIL irq_unmask: got %b want 1", irq); end
  endtask

  task automatic test_w1c_collision();
    logic [W-1:0] rd, erd;
    logic err, eerr;
    gpio_in[0] = 1'b0;
    repeat (5) @(negedge PCLK);
    gpio_in[0] = 1'b1;
    @(posedge PCLK);
    // Commit edge coincides with the capture edge of the new rise.
    xfer(1'b1, 5'd8, 16'h0003, rd, err, erd, eerr);
    xfer(1'b0, 5'd8, '0, rd, err, erd, eerr);
    n_cmp++; if (rd !== 16'h0001) begin n_bad++; $display("FAIL w1c_collision: got %h want 0001", rd); end
    n_cmp++; if (rd !== erd) begin n_bad++; $display("FAIL w1c_model: got %h want %h", rd, erd); end
    idle();
  endtask

  task automatic test_errors();
    logic [W-1:0] rd, erd, in_before;
    logic err, eerr;
    xfer(1'b0, 5'd2, '0, in_before, err, erd, eerr);
    xfer(1'b1, 5'd2, 16'(~in_before), rd, err, erd, eerr);
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL wr_in_err: got %b want 1", err); end
    xfer(1'b0, 5'd2, '0, rd, err, erd, eerr);
    n_cmp++; if (rd !== in_before) begin n_bad++; $display("FAIL in_unchanged: got %h want %h", rd, in_before); end
    xfer(1'b0, 5'h1F, '0, rd, err, erd, eerr);
    n_cmp++; if (err !== 1'b1 || rd !== '0) begin n_bad++; $display("FAIL rd_1f: got %h/%b want 0/1", rd, err); end
    xfer(1'b1, 5'h0C, 16'hFFFF, rd, err, erd, eerr);
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL wr_0c_err: got %b want 1", err); end
    xfer(1'b0, 5'd0, '0, rd, err, erd, eerr);
    n_cmp++; if (rd !== 16'h00FF) begin n_bad++; $display("FAIL dir_unchanged: got %h want 00ff", rd); end
    idle();
  endtask

  task automatic test_random();
    logic [W-1:0] rd, erd, data;
    logic err, eerr, wr;
    logic [4:0] addr;
    for (int it = 0; it < 200; it++) begin
      if ($urandom_range(0, 3) == 0) begin
        idle();
        gpio_in = gpio_in ^ W'($urandom & $urandom);
        n_cmp++; if (gpio_out !== m_out || gpio_oe !== m_dir) begin
          n_bad++; $display("FAIL rnd_pads[%0d]: got %h/%h want %h/%h", it, gpio_out, gpio_oe, m_out, m_dir);
        end
        n_cmp++; if (irq !== m_irq) begin n_bad++; $display("FAIL rnd_irq[%0d]: got %b want %b", it, irq, m_irq); end
      end
      addr = ($urandom_range(0, 7) == 0) ? 5'($urandom) : 5'($urandom_range(0, 8));
      wr   = 1'($urandom);
      data = W'($urandom);
      xfer(wr, addr, data, rd, err, erd, eerr);
      n_cmp++; if (rd !== erd || err !== eerr) begin
        n_bad++; $display("FAIL rnd_xfer[%0d] a=%h w=%b: got %h/%b want %h/%b", it, addr, wr, rd, err, erd, eerr);
      end
    end
    idle();
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] rd, erd;
    logic err, eerr;
    xfer(1'b1, 5'd1, 16'h1234, rd, err, erd, eerr);
    xfer(1'b1, 5'd0, 16'hFFFF, rd, err, erd, eerr);
    idle();
    @(negedge PCLK);
    bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b1; bus.PADDR = 5'd1; bus.PWDATA = 16'hBEEF;
    @(negedge PCLK);
    bus.PENABLE = 1'b1;
    #1 PRESETn = 1'b0;
    #1;
    n_cmp++; if (gpio_out !== '0 || gpio_oe !== '0) begin
      n_bad++; $display("FAIL mid_reset_pads: got %h/%h want 0/0", gpio_out, gpio_oe);
    end
    n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL mid_reset_irq: got %b want 0", irq); end
    @(negedge PCLK);
    bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
    PRESETn = 1'b1;
    repeat (4) @(negedge PCLK);
    xfer(1'b0, 5'd1, '0, rd, err, erd, eerr);
    n_cmp++; if (rd !== '0) begin n_bad++; $display("FAIL mid_reset_out: got %h want 0", rd); end
    xfer(1'b0, 5'd8, '0, rd, err, erd, eerr);
    n_cmp++; if (rd !== '0) begin n_bad++; $display("FAIL powerup_is: got %h want 0", rd); end
    idle();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0; bus.PADDR = '0; bus.PWDATA = '0;
    gpio_in = '0;
    test_reset();
    test_dir_out();
    test_rise_irq();
    test_fall_no_ie();
    test_w1c_collision();
    test_errors();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
